// File: rtl/gcd_stein_if.sv
// Handshake bundle for the binary-GCD unit: operand request channel and result channel.
interface gcd_stein_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic             zero_flag;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output in_valid, a_in, b_in, abort, out_ready,
        input  in_ready, out_valid, gcd_out, zero_flag, iter_cnt
    );

    modport slave (
        input  in_valid, a_in, b_in, abort, out_ready,
        output in_ready, out_valid, gcd_out, zero_flag, iter_cnt
    );
endinterface

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine: strips common factors of two, then reduces odd/even
// pairs until equal; result is held until the consumer accepts it.
module gcd_stein_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    gcd_stein_if.slave  bus
);
    localparam int unsigned K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, a_next, b, b_next;
    logic [K_W-1:0]   k, k_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [WIDTH-1:0] gcd_q, gcd_next;
    logic             zf_q, zf_next;
    logic [CNT_W-1:0] itc_q, itc_next;
    logic             in_ready_q, out_valid_q;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        a_next     = a;
        b_next     = b;
        k_next     = k;
        cnt_next   = cnt;
        gcd_next   = gcd_q;
        zf_next    = zf_q;
        itc_next   = itc_q;
        cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next   = bus.a_in;
                    b_next   = bus.b_in;
                    k_next   = '0;
                    cnt_next = '0;
                    if (bus.a_in == '0 || bus.b_in == '0) begin
                        state_next = DONE;
                        gcd_next   = bus.a_in | bus.b_in;
                        zf_next    = (bus.a_in == '0) && (bus.b_in == '0);
                        itc_next   = '0;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                cnt_next = cnt_inc;
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (!a[0] && !b[0]) begin
                    a_next = a >> 1;
                    b_next = b >> 1;
                    k_next = k + 1'b1;
                end else begin
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                cnt_next = cnt_inc;
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (a == b) begin
                    // k never exceeds the trailing zeros shared by the operands, so this cannot overflow
                    gcd_next   = a << k;
                    zf_next    = 1'b0;
                    itc_next   = cnt_inc;
                    state_next = DONE;
                end else if (!a[0]) begin
                    a_next = a >> 1;
                end else if (!b[0]) begin
                    b_next = b >> 1;
                end else if (a > b) begin
                    a_next = (a - b) >> 1;
                end else begin
                    b_next = (b - a) >> 1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags are registered from the next state
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            k           <= '0;
            cnt         <= '0;
            gcd_q       <= '0;
            zf_q        <= 1'b0;
            itc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            a           <= a_next;
            b           <= b_next;
            k           <= k_next;
            cnt         <= cnt_next;
            gcd_q       <= gcd_next;
            zf_q        <= zf_next;
            itc_q       <= itc_next;
            in_ready_q  <= (state_next == IDLE);
            out_valid_q <= (state_next == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.gcd_out   = gcd_q;
    assign bus.zero_flag = zf_q;
    assign bus.iter_cnt  = itc_q;
endmodule

// File: tb/tb_gcd_stein_unit.sv
// Randomized bench for gcd_stein_unit: Euclid-based reference plus directed corner cases.
module tb_gcd_stein_unit;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        int unsigned g;
        int unsigned zf;
        int unsigned it;
    } exp_t;

    logic clk;
    logic rst_n;
    gcd_stein_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gcd_stein_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_err;
    exp_t exp_q[$];
    int unsigned hold_g, hold_zf, hold_it;
    int unsigned last_g, last_zf, last_it;
    int   rdy_mode;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned euclid(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Cycle count follows the algorithm's rules, one step per clock
    function automatic int unsigned stein_cycles(input int unsigned x, input int unsigned y);
        int unsigned n;
        if (x == 0 || y == 0) return 0;
        n = 0;
        while (x % 2 == 0 && y % 2 == 0) begin
            x = x / 2;
            y = y / 2;
            n++;
        end
        n++;
        forever begin
            n++;
            if (x == y) break;
            else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic exp_t model(input int unsigned x, input int unsigned y);
        exp_t e;
        e.g  = euclid(x, y);
        e.zf = (x == 0 && y == 0) ? 1 : 0;
        e.it = stein_cycles(x, y);
        return e;
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Compare process: result channel against the model queue every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            hold_g  = 0;
            hold_zf = 0;
            hold_it = 0;
        end else if (bus.out_valid) begin
            chk("in_ready_in_done", 32'(bus.in_ready), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("gcd_out", 32'(bus.gcd_out), exp_q[0].g);
                chk("zero_flag", 32'(bus.zero_flag), exp_q[0].zf);
                chk("iter_cnt", 32'(bus.iter_cnt), exp_q[0].it);
                if (bus.out_ready) begin
                    last_g  = 32'(bus.gcd_out);
                    last_zf = 32'(bus.zero_flag);
                    last_it = 32'(bus.iter_cnt);
                    hold_g  = exp_q[0].g;
                    hold_zf = exp_q[0].zf;
                    hold_it = exp_q[0].it;
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("gcd_out_hold", 32'(bus.gcd_out), hold_g);
            chk("zero_flag_hold", 32'(bus.zero_flag), hold_zf);
            chk("iter_cnt_hold", 32'(bus.iter_cnt), hold_it);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned x, input int unsigned y, input bit push);
        int g;
        bus.in_valid = 1'b1;
        bus.a_in     = WIDTH'(x);
        bus.b_in     = WIDTH'(y);
        g = 0;
        while (!bus.in_ready && g < 1000) begin
            tick();
            g++;
        end
        if (g >= 1000) chk("accept_timeout", 1, 0);
        tick();
        bus.in_valid = 1'b0;
        if (push) exp_q.push_back(model(x, y));
    endtask

    task automatic wait_valid();
        int g;
        g = 0;
        while (!bus.out_valid && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) chk("out_valid_timeout", 1, 0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            tick();
            g++;
        end
        if (g >= 5000) chk("drain_timeout", 32'(exp_q.size()), 0);
        tick();
    endtask

    initial begin
        int unsigned x, y, s;
        n_vec = 0;
        n_err = 0;
        rdy_mode = 0;
        hold_g = 0; hold_zf = 0; hold_it = 0;
        last_g = 0; last_zf = 0; last_it = 0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.abort    = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_gcd_out", 32'(bus.gcd_out), 0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        // 12,18: gcd 6 after 5 busy cycles, out_valid for one cycle
        send(12, 18, 1);
        wait_valid();
        tick();
        chk("valid_one_cycle", 32'(bus.out_valid), 0);
        chk("dir_12_18_gcd", last_g, 6);
        chk("dir_12_18_iter", last_it, 5);

        // Both zero: result on the cycle after accept
        send(0, 0, 1);
        chk("zero_latency", 32'(bus.out_valid), 1);
        tick();
        chk("dir_0_0_gcd", last_g, 0);
        chk("dir_0_0_zf", last_zf, 1);
        chk("dir_0_0_iter", last_it, 0);
        send(0, 35, 1);
        drain();
        chk("dir_0_35_gcd", last_g, 35);
        chk("dir_0_35_zf", last_zf, 0);
        send(65535, 65534, 1);
        drain();
        chk("dir_ffff_fffe_gcd", last_g, 1);
        send(32768, 49152, 1);
        drain();
        chk("dir_8000_c000_gcd", last_g, 16384);

        // Back-pressure: result held, new operands ignored
        rdy_mode = 2;
        send(12, 18, 1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a_in     = 16'd7;
            bus.b_in     = 16'd3;
            tick();
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        tick();
        tick();
        chk("bp_exit_valid", 32'(bus.out_valid), 0);
        chk("bp_exit_ready", 32'(bus.in_ready), 1);

        // Abort one cycle after accept
        send(255, 17, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_gcd_keep", 32'(bus.gcd_out), 6);
        repeat (5) tick();
        send(48, 36, 1);
        drain();
        chk("dir_48_36_gcd", last_g, 12);

        // Reset pulse while in REDUCE
        send(255, 17, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_gcd_out", 32'(bus.gcd_out), 0);
        chk("arst_iter_cnt", 32'(bus.iter_cnt), 0);
        chk("arst_zero_flag", 32'(bus.zero_flag), 0);
        tick();
        tick();
        rst_n = 1'b0;
        repeat (30) tick();
        chk("arst_no_result", 32'(bus.out_valid), 0);

        // Randomized traffic with random consumer back-pressure
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: begin x = $urandom_range(0, 65535); y = $urandom_range(0, 65535); end
                1: begin x = $urandom_range(0, 20); y = $urandom_range(0, 20); end
                2: begin
                    s = $urandom_range(0, 8);
                    x = ($urandom_range(1, 255) << s) & 32'hFFFF;
                    y = ($urandom_range(1, 255) << s) & 32'hFFFF;
                end
                default: begin
                    x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : 0;
                    y = (x == 0) ? $urandom_range(0, 65535) : 0;
                end
            endcase
            send(x, y, 1);
        end
        drain();
        rdy_mode = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
